// File: rtl/alu_pkg.sv
// Shared opcode encodings and multiplier FSM states for the pipelined ALU.
// Opcodes 0001-0111 keep the encodings of the original single-cycle ALU.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_AND  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_XNOR = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b1001;
    localparam logic [3:0] ALU_SLTU = 4'b1010;
    localparam logic [3:0] ALU_MUL  = 4'b1011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per clock,
// then waits in DONE until the output stage can take the product.
module alu_mul_seq import alu_pkg::*; #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [DATA_WIDTH-1:0]     a,
    input  logic [DATA_WIDTH-1:0]     b,
    input  logic                      take,
    output logic                      done,
    output logic [2*DATA_WIDTH-1:0]   product,
    output logic                      busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    mul_state_e                state_q, state_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [2*DATA_WIDTH-1:0]   acc_q, acc_d;
    logic [2*DATA_WIDTH-1:0]   mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0]     mplier_q, mplier_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    // The multiplicand shifts left and the multiplier shifts right, so bit 0
    // of mplier_q is always the bit that decides this cycle's partial product.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    count_d  = '0;
                    acc_d    = '0;
                    mcand_d  = {{DATA_WIDTH{1'b0}}, a};
                    mplier_d = b;
                end
            end
            RUN: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 1'b1;
                if (count_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (take) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign done    = (state_q == DONE);
    assign busy    = (state_q != IDLE);
    assign product = acc_q;

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU between register read and writeback: single-cycle ops plus
// an iterative multiply that stalls the input channel while it runs.
module alu_pipe import alu_pkg::*; #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [3:0]            aluctrl,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] Z,
    output logic                  carry,
    output logic                  overflow,
    output logic                  zero,
    output logic                  negative,
    output logic                  busy
);

    localparam int SHAMT_W = $clog2(DATA_WIDTH);
    localparam int MSB     = DATA_WIDTH - 1;

    logic [SHAMT_W-1:0]      shamt;
    logic [DATA_WIDTH:0]     sum_ext;
    logic [DATA_WIDTH-1:0]   diff;
    logic [DATA_WIDTH-1:0]   alu_z;
    logic                    alu_c, alu_v;

    logic                    take, accept, mul_start, mul_done, mul_busy;
    logic                    load_alu, load_mul;
    logic [2*DATA_WIDTH-1:0] product;

    logic [DATA_WIDTH-1:0]   new_z;
    logic                    new_c, new_v;

    logic [DATA_WIDTH-1:0]   z_q, z_d;
    logic                    carry_q, carry_d;
    logic                    overflow_q, overflow_d;
    logic                    zero_q, zero_d;
    logic                    negative_q, negative_d;
    logic                    out_valid_q, out_valid_d;

    assign shamt   = B[SHAMT_W-1:0];
    assign sum_ext = {1'b0, A} + {1'b0, B};
    assign diff    = A - B;

    always_comb begin
        alu_z = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (aluctrl)
            ALU_ADD: begin
                alu_z = sum_ext[DATA_WIDTH-1:0];
                alu_c = sum_ext[DATA_WIDTH];
                alu_v = (A[MSB] == B[MSB]) && (alu_z[MSB] != A[MSB]);
            end
            ALU_SUB: begin
                alu_z = diff;
                alu_c = (A < B);
                alu_v = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]);
            end
            ALU_AND:  alu_z = A & B;
            ALU_OR:   alu_z = A | B;
            ALU_XNOR: alu_z = ~(A ^ B);
            ALU_SLL:  alu_z = A << shamt;
            ALU_SRL:  alu_z = A >> shamt;
            ALU_SRA:  alu_z = DATA_WIDTH'($signed(A) >>> shamt);
            ALU_SLT:  alu_z = {{(DATA_WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            ALU_SLTU: alu_z = {{(DATA_WIDTH-1){1'b0}}, (A < B)};
            default:  alu_z = '0;
        endcase
    end

    // The output stage is free when empty or being drained this edge.
    assign take      = !out_valid_q || out_ready;
    assign in_ready  = !mul_busy && take;
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (aluctrl == ALU_MUL);
    assign load_alu  = accept && (aluctrl != ALU_MUL);
    assign load_mul  = mul_done && take;

    alu_mul_seq #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (A),
        .b       (B),
        .take    (take),
        .done    (mul_done),
        .product (product),
        .busy    (mul_busy)
    );

    assign new_z = load_mul ? product[DATA_WIDTH-1:0] : alu_z;
    assign new_c = load_mul ? 1'b0 : alu_c;
    assign new_v = load_mul ? (|product[2*DATA_WIDTH-1:DATA_WIDTH]) : alu_v;

    always_comb begin
        z_d         = z_q;
        carry_d     = carry_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        negative_d  = negative_q;
        out_valid_d = out_valid_q && !out_ready;
        if (load_alu || load_mul) begin
            z_d         = new_z;
            carry_d     = new_c;
            overflow_d  = new_v;
            zero_d      = (new_z == '0);
            negative_d  = new_z[MSB];
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q         <= '0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            negative_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            z_q         <= z_d;
            carry_q     <= carry_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
            negative_q  <= negative_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign Z         = z_q;
    assign carry     = carry_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;
    assign negative  = negative_q;
    assign out_valid = out_valid_q;
    assign busy      = mul_busy;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vector table, handshake corner
// sequences, and randomized traffic against an arithmetic reference model.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    typedef struct packed {
        logic [31:0] z;
        logic        c;
        logic        v;
    } res_t;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] z;
        logic        c;
        logic        v;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [3:0]  aluctrl = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] Z;
    logic        carry, overflow, zero, negative, busy;

    int checks = 0;
    int errors = 0;

    vec_t vecs[$];
    res_t sb_q[$];

    alu_pipe #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .aluctrl   (aluctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Z         (Z),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference computed with 64-bit integer arithmetic straight from the opcode rules.
    function automatic res_t refModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        res_t        r;
        longint      sa, sb, s;
        logic [63:0] ua, ub, p;
        int          n;
        r.z = '0; r.c = 1'b0; r.v = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        n  = int'(b % 32);
        case (op)
            ALU_ADD: begin
                p = ua + ub; r.z = p[31:0]; r.c = p[32];
                s = sa + sb; r.v = (s > SMAX) || (s < SMIN);
            end
            ALU_SUB: begin
                r.z = a - b; r.c = (ua < ub);
                s = sa - sb; r.v = (s > SMAX) || (s < SMIN);
            end
            ALU_AND:  r.z = a & b;
            ALU_OR:   r.z = a | b;
            ALU_XNOR: r.z = ~(a ^ b);
            ALU_SLL:  r.z = a << n;
            ALU_SRL:  r.z = a >> n;
            ALU_SRA:  begin s = sa >>> n; p = s; r.z = p[31:0]; end
            ALU_SLT:  r.z = (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU: r.z = (ua < ub) ? 32'd1 : 32'd0;
            ALU_MUL:  begin p = ua * ub; r.z = p[31:0]; r.v = (p[63:32] != 0); end
            default:  r.z = '0;
        endcase
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkResult(input string name, input logic [31:0] ez, input logic ec, input logic ev);
        checkOutput({name, "_valid"}, 64'(out_valid), 64'd1);
        checkOutput({name, "_z"}, 64'(Z), 64'(ez));
        checkOutput({name, "_carry"}, 64'(carry), 64'(ec));
        checkOutput({name, "_ovf"}, 64'(overflow), 64'(ev));
        checkOutput({name, "_zero"}, 64'(zero), 64'(ez == 32'd0));
        checkOutput({name, "_neg"}, 64'(negative), 64'(ez[31]));
    endtask

    // Presents one operation and returns #1 after the edge that accepted it.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        @(negedge clk);
        aluctrl  = op;
        A        = a;
        B        = b;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            errors++;
            $display("[TB] FAIL accept_timeout: in_ready stayed 0, expected 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic waitResult(input string name);
        int n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) begin
            errors++;
            $display("[TB] FAIL %s_timeout: out_valid stayed 0, expected 1", name);
        end
    endtask

    task automatic drainOutput();
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        logic        stall_ok;
        res_t        exp_r;
        res_t        got_r;
        int          n;

        vecs.push_back('{"add_carry",  ALU_ADD,  32'hFFFF_FFFF, 32'h1,          32'h0,          1'b1, 1'b0});
        vecs.push_back('{"add_ovf",    ALU_ADD,  32'h7FFF_FFFF, 32'h1,          32'h8000_0000, 1'b0, 1'b1});
        vecs.push_back('{"sub_borrow", ALU_SUB,  32'd5,         32'd7,          32'hFFFF_FFFE, 1'b1, 1'b0});
        vecs.push_back('{"sub_ovf",    ALU_SUB,  32'h8000_0000, 32'h1,          32'h7FFF_FFFF, 1'b0, 1'b1});
        vecs.push_back('{"and",        ALU_AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0});
        vecs.push_back('{"or",         ALU_OR,   32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0});
        vecs.push_back('{"xnor_zero",  ALU_XNOR, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0,          1'b0, 1'b0});
        vecs.push_back('{"xnor_ones",  ALU_XNOR, 32'h0,         32'h0,          32'hFFFF_FFFF, 1'b0, 1'b0});
        vecs.push_back('{"sll_wrap",   ALU_SLL,  32'h1,         32'h25,         32'h20,         1'b0, 1'b0});
        vecs.push_back('{"sll_zero",   ALU_SLL,  32'h1234_5678, 32'h0,          32'h1234_5678, 1'b0, 1'b0});
        vecs.push_back('{"srl_31",     ALU_SRL,  32'h8000_0000, 32'd31,         32'h1,          1'b0, 1'b0});
        vecs.push_back('{"sra_31",     ALU_SRA,  32'h8000_0000, 32'd31,         32'hFFFF_FFFF, 1'b0, 1'b0});
        vecs.push_back('{"sra_pos",    ALU_SRA,  32'h4000_0000, 32'd4,          32'h0400_0000, 1'b0, 1'b0});
        vecs.push_back('{"slt_neg",    ALU_SLT,  32'hFFFF_FFFF, 32'h1,          32'h1,          1'b0, 1'b0});
        vecs.push_back('{"slt_pos",    ALU_SLT,  32'h1,         32'hFFFF_FFFF, 32'h0,          1'b0, 1'b0});
        vecs.push_back('{"sltu_big",   ALU_SLTU, 32'hFFFF_FFFF, 32'h1,          32'h0,          1'b0, 1'b0});
        vecs.push_back('{"sltu_small", ALU_SLTU, 32'h1,         32'hFFFF_FFFF, 32'h1,          1'b0, 1'b0});
        vecs.push_back('{"op_0000",    4'b0000,  32'h5,         32'h3,          32'h0,          1'b0, 1'b0});
        vecs.push_back('{"op_1111",    4'b1111,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,          1'b0, 1'b0});
        vecs.push_back('{"mul_trunc",  ALU_MUL,  32'h0001_0000, 32'h0001_0000, 32'h0,          1'b0, 1'b1});
        vecs.push_back('{"mul_7x6",    ALU_MUL,  32'd7,         32'd6,          32'd42,         1'b0, 1'b0});

        // Reset state
        #2;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_z", 64'(Z), 64'd0);
        checkOutput("rst_flags", 64'({carry, overflow, zero, negative}), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed vector table");
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            waitResult(vecs[i].name);
            checkResult(vecs[i].name, vecs[i].z, vecs[i].c, vecs[i].v);
        end
        drainOutput();

        $display("[TB] back-to-back single-cycle ops");
        @(negedge clk);
        aluctrl = ALU_SUB; A = 32'd5; B = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        checkResult("b2b_sub", 32'hFFFF_FFFE, 1'b1, 1'b0);
        aluctrl = ALU_SLT; A = 32'hFFFF_FFFF; B = 32'd1;
        @(posedge clk); #1;
        checkResult("b2b_slt", 32'd1, 1'b0, 1'b0);
        aluctrl = ALU_SLTU; A = 32'hFFFF_FFFF; B = 32'd1;
        @(posedge clk); #1;
        checkResult("b2b_sltu", 32'd0, 1'b0, 1'b0);
        in_valid = 1'b0;
        drainOutput();

        $display("[TB] multiply latency and input stall");
        @(negedge clk);
        aluctrl = ALU_MUL; A = 32'd7; B = 32'd6; in_valid = 1'b1;
        #1;
        checkOutput("mul_lat_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("mul_lat_busy", 64'(busy), 64'd1);
        stall_ok = 1'b1;
        for (int k = 0; k <= 32; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (out_valid || in_ready) stall_ok = 1'b0;
        end
        checkOutput("mul_lat_stall", 64'(stall_ok), 64'd1);
        @(posedge clk); #1;
        checkResult("mul_lat_result", 32'd42, 1'b0, 1'b0);
        drainOutput();

        $display("[TB] back-pressure around multiply completion");
        out_ready = 1'b0;
        applyStimulus(ALU_MUL, 32'h1234, 32'h10);
        waitResult("bp_mul");
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checkOutput("bp_hold_z", 64'(Z), 64'h12340);
            checkOutput("bp_hold_valid", 64'(out_valid), 64'd1);
            checkOutput("bp_hold_in_ready", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp_release_valid", 64'(out_valid), 64'd0);

        $display("[TB] reset during multiply");
        applyStimulus(ALU_MUL, 32'hFFFF, 32'hFFFF);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rstmul_busy", 64'(busy), 64'd0);
        checkOutput("rstmul_valid", 64'(out_valid), 64'd0);
        checkOutput("rstmul_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(ALU_ADD, 32'd2, 32'd3);
        checkResult("rstmul_add", 32'd5, 1'b0, 1'b0);
        drainOutput();

        $display("[TB] randomized traffic");
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = $urandom_range(0, 1) == 1;
            aluctrl   = 4'($urandom_range(0, 15));
            if (aluctrl == ALU_MUL && $urandom_range(0, 3) != 0) aluctrl = ALU_ADD;
            A = $urandom;
            B = $urandom;
            if ($urandom_range(0, 7) == 0) B = 32'($urandom_range(0, 40));
            if ($urandom_range(0, 7) == 0) A = 32'h8000_0000;
            #1;
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL rand_unexpected: got out_valid 1, expected 0");
                end else begin
                    exp_r = sb_q.pop_front();
                    got_r.z = Z; got_r.c = carry; got_r.v = overflow;
                    checkOutput("rand_result", 64'(got_r), 64'(exp_r));
                    checkOutput("rand_zn", 64'({zero, negative}), 64'({exp_r.z == 32'd0, exp_r.z[31]}));
                end
            end
            if (in_valid && in_ready) sb_q.push_back(refModel(aluctrl, A, B));
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            #1;
            if (out_valid) begin
                exp_r = sb_q.pop_front();
                got_r.z = Z; got_r.c = carry; got_r.v = overflow;
                checkOutput("drain_result", 64'(got_r), 64'(exp_r));
            end
            @(negedge clk);
            n++;
        end
        checkOutput("drain_empty", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
